// File: rtl/sd_block_loader_if.sv
// SPI byte-engine handshake plus RAM write request port of the sector loader.
// master = loader side, slave = engine / RAM arbiter side.
interface sd_block_loader_if;
    logic        sd_signal;
    logic [1:0]  sd_cmd;
    logic [7:0]  sd_out;
    logic [7:0]  sd_din;
    logic        sd_busy;
    logic        sd_timeout;
    logic        ram_req;
    logic        ram_ack;
    logic [16:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_we;

    modport master (
        output sd_signal, sd_cmd, sd_out,
        input  sd_din, sd_busy, sd_timeout,
        output ram_req, ram_address, ram_data, ram_we,
        input  ram_ack
    );

    modport slave (
        input  sd_signal, sd_cmd, sd_out,
        output sd_din, sd_busy, sd_timeout,
        input  ram_req, ram_address, ram_data, ram_we,
        output ram_ack
    );
endinterface

// File: rtl/sd_block_loader.sv
// CMD17 single-sector reader: sequences the SPI byte engine and streams the
// 512 data bytes into RAM through a req/ack write port.
module sd_block_loader #(
    parameter int R1_TRIES    = 8,
    parameter int TOKEN_TRIES = 4096,
    parameter int SDHC        = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] lba,
    input  logic [16:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    sd_block_loader_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CSLOW, S_CMD, S_R1, S_TOKEN, S_DATA, S_RAMWR, S_CRC, S_CSHIGH, S_ABORT
    } state_t;
    typedef enum logic [1:0] {P_ISSUE, P_DEAD, P_WAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] poll_q, poll_d;
    logic [8:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [16:0] dst_q, dst_d;
    logic [7:0]  data_q, data_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    logic        op_active, op_done;
    logic [1:0]  cmd_w;
    logic [7:0]  out_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= P_ISSUE;
            step_q  <= '0;
            poll_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    // Every SPI-driving state runs the same issue / dead / wait-for-idle cadence.
    assign op_active = (state_q != S_IDLE) && (state_q != S_RAMWR);
    assign op_done   = op_active && (phase_q == P_WAIT) && !bus.sd_busy;

    always_comb begin
        cmd_w = 2'd1;
        out_w = 8'hFF;
        case (state_q)
            S_CSLOW:  if (step_q == 3'd0) cmd_w = 2'd2;
            S_CSHIGH: if (step_q == 3'd0) cmd_w = 2'd3;
            S_ABORT:  cmd_w = 2'd3;
            S_CMD: begin
                case (step_q)
                    3'd0:    out_w = 8'h51;
                    3'd1:    out_w = addr_q[31:24];
                    3'd2:    out_w = addr_q[23:16];
                    3'd3:    out_w = addr_q[15:8];
                    3'd4:    out_w = addr_q[7:0];
                    default: out_w = 8'hFF;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        poll_d  = poll_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        data_d  = data_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        code_d  = code_q;

        if (op_active) begin
            case (phase_q)
                P_ISSUE: phase_d = P_DEAD;
                P_DEAD:  phase_d = P_WAIT;
                default: if (!bus.sd_busy) phase_d = P_ISSUE;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // done/error still high means we completed this very cycle
                if (start && !done_q && !error_q) begin
                    addr_d  = (SDHC != 0) ? lba : (lba << 9);
                    dst_d   = dst_addr;
                    idx_d   = '0;
                    poll_d  = '0;
                    step_d  = '0;
                    phase_d = P_ISSUE;
                    busy_d  = 1'b1;
                    code_d  = 2'd0;
                    state_d = S_CSLOW;
                end
            end
            S_RAMWR: begin
                if (bus.ram_ack) begin
                    req_d   = 1'b0;
                    idx_d   = idx_q + 9'd1;
                    step_d  = '0;
                    state_d = (idx_q == 9'd511) ? S_CRC : S_DATA;
                end
            end
            default: begin
                if (op_done) begin
                    if (bus.sd_timeout && state_q != S_ABORT) begin
                        state_d = S_ABORT;
                        code_d  = 2'd3;
                    end else begin
                        case (state_q)
                            S_CSLOW: begin
                                step_d = step_q + 3'd1;
                                if (step_q == 3'd1) begin
                                    step_d  = '0;
                                    state_d = S_CMD;
                                end
                            end
                            S_CMD: begin
                                step_d = step_q + 3'd1;
                                if (step_q == 3'd5) begin
                                    poll_d  = '0;
                                    state_d = S_R1;
                                end
                            end
                            S_R1: begin
                                poll_d = poll_q + 16'd1;
                                if (!bus.sd_din[7]) begin
                                    poll_d = '0;
                                    if (bus.sd_din == 8'h00) begin
                                        state_d = S_TOKEN;
                                    end else begin
                                        state_d = S_ABORT;
                                        code_d  = 2'd0;
                                    end
                                end else if (poll_q == 16'(R1_TRIES - 1)) begin
                                    state_d = S_ABORT;
                                    code_d  = 2'd1;
                                end
                            end
                            S_TOKEN: begin
                                poll_d = poll_q + 16'd1;
                                if (bus.sd_din == 8'hFE) begin
                                    state_d = S_DATA;
                                end else if (bus.sd_din[7:5] == 3'b000 ||
                                             poll_q == 16'(TOKEN_TRIES - 1)) begin
                                    state_d = S_ABORT;
                                    code_d  = 2'd2;
                                end
                            end
                            S_DATA: begin
                                data_d  = bus.sd_din;
                                req_d   = 1'b1;
                                state_d = S_RAMWR;
                            end
                            S_CRC: begin
                                step_d = step_q + 3'd1;
                                if (step_q == 3'd1) begin
                                    step_d  = '0;
                                    state_d = S_CSHIGH;
                                end
                            end
                            S_CSHIGH: begin
                                step_d = step_q + 3'd1;
                                if (step_q == 3'd1) begin
                                    state_d = S_IDLE;
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                end
                            end
                            S_ABORT: begin
                                state_d = S_IDLE;
                                error_d = 1'b1;
                                busy_d  = 1'b0;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    assign bus.sd_signal   = op_active && (phase_q == P_ISSUE);
    assign bus.sd_cmd      = bus.sd_signal ? cmd_w : 2'd0;
    assign bus.sd_out      = bus.sd_signal ? out_w : 8'h00;
    assign bus.ram_req     = req_q;
    assign bus.ram_address = dst_q + {8'd0, idx_q};
    assign bus.ram_data    = data_q;
    assign bus.ram_we      = req_q & bus.ram_ack;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = code_q;
endmodule
